// File: rtl/dec_unbinder_seq.sv
// Sequential hypervector unbinder: captures NUM_CH bound vectors on start and
// streams each channel back out rotated right by its bind shift.
//
//   state  | meaning
//   IDLE   | waiting for start_decoding; bank holds the last capture
//   RUN    | streaming channel out_ch with valid/ready handshake
//   DONE   | one-cycle done pulse, then back to IDLE
module dec_unbinder_seq #(
  parameter int HV_DIM                = 1024,
  parameter int NUM_CH                = 10,
  parameter int SHIFTS [0:NUM_CH-1]   = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10},
  parameter int CH_W                  = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start_decoding,
  input  logic [HV_DIM-1:0] shifted_hv [0:NUM_CH-1],
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch,
  output logic [HV_DIM-1:0] level_hv,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [CH_W-1:0]   ch_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;
  logic [HV_DIM-1:0] hv_q;
  logic [HV_DIM-1:0] bank_q [0:NUM_CH-1];

  logic [HV_DIM-1:0] unb [0:NUM_CH-1];
  logic [HV_DIM-1:0] cap0_hv;
  logic [HV_DIM-1:0] hv_d;
  logic [CH_W-1:0]   ch_d;
  logic              last_ch;
  logic              xfer;

  // Lossless rotate-right: bit k of the result comes from bit (k+s) mod HV_DIM.
  function automatic logic [HV_DIM-1:0] rotr(input logic [HV_DIM-1:0] v, input int s);
    logic [HV_DIM-1:0] r;
    for (int k = 0; k < HV_DIM; k++) begin
      r[k] = v[(k + (s % HV_DIM)) % HV_DIM];
    end
    return r;
  endfunction

  // Shift amounts are constants, so each rotator is pure wiring.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_unbind
    assign unb[i] = rotr(bank_q[i], SHIFTS[i]);
  end

  // Channel 0 is unbound straight from the input so it is valid one edge after start.
  assign cap0_hv = rotr(shifted_hv[0], SHIFTS[0]);

  assign ch_d    = ch_q + CH_W'(1);
  assign last_ch = (ch_q == CH_W'(NUM_CH - 1));
  assign xfer    = valid_q && out_ready;

  always_comb begin
    hv_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_d == CH_W'(i)) hv_d = unb[i];
    end
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hv_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) bank_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_decoding) begin
            for (int i = 0; i < NUM_CH; i++) bank_q[i] <= shifted_hv[i];
            ch_q    <= '0;
            hv_q    <= cap0_hv;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (xfer) begin
            if (last_ch) begin
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              ch_q <= ch_d;
              hv_q <= hv_d;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign out_ch    = ch_q;
  assign level_hv  = hv_q;
  assign done      = done_q;

endmodule

// File: tb/tb_dec_unbinder_seq.sv
// Self-checking bench for dec_unbinder_seq: level vectors are encoded with
// rotate-left and the streamed outputs must recover them exactly, in order.
module tb_dec_unbinder_seq;

  localparam int HV  = 16;
  localparam int NCH = 10;
  localparam int CW  = 4;
  localparam int SH [0:NCH-1] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};

  logic          clk = 1'b0;
  logic          nrst = 1'b1;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic [HV-1:0] shv [0:NCH-1];
  logic [HV-1:0] lvl [0:NCH-1];
  logic          busy, out_valid, done;
  logic [CW-1:0] out_ch;
  logic [HV-1:0] level_hv;

  int n_assert = 0;
  int n_fail   = 0;
  int n_done   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) n_done++;

  dec_unbinder_seq #(
    .HV_DIM(HV),
    .NUM_CH(NCH),
    .SHIFTS(SH),
    .CH_W(CW)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .start_decoding(start),
    .shifted_hv(shv),
    .busy(busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ch(out_ch),
    .level_hv(level_hv),
    .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Binding as the encoder does it: rotate left by s with wrap-around.
  function automatic logic [HV-1:0] rotl(input logic [HV-1:0] x, input int s);
    logic [31:0] w;
    w = {16'h0000, x};
    w = ((w << s) | (w >> (HV - s))) & 32'h0000_FFFF;
    return w[HV-1:0];
  endfunction

  task automatic encode;
    for (int i = 0; i < NCH; i++) shv[i] = rotl(lvl[i], SH[i]);
  endtask

  task automatic rand_levels;
    for (int i = 0; i < NCH; i++) lvl[i] = HV'($urandom);
    encode();
  endtask

  // mode 0: ready always high, 1: ready pattern 1,0,0,1, 2: random ready.
  // inject: pulse start with scrambled inputs while in RUN and in DONE.
  task automatic run_seq(input int mode, input bit inject);
    int idx;
    int cyc;
    int d0;
    bit rdy;
    d0 = n_done;
    start = 1'b1;
    tick();
    start = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < NCH && cyc < 200) begin
      chk("valid_run", out_valid, 1);
      chk("busy_run", busy, 1);
      chk("done_early", done, 0);
      chk("out_ch", out_ch, idx);
      chk("level_hv", level_hv, lvl[idx]);
      if (inject && cyc == 2) begin
        start = 1'b1;
        for (int i = 0; i < NCH; i++) shv[i] = HV'($urandom);
      end else begin
        start = 1'b0;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      tick();
      if (rdy) idx++;
      cyc++;
    end
    start = 1'b0;
    chk("transfer_count", idx, NCH);
    chk("done_pulse", done, 1);
    chk("valid_after_last", out_valid, 0);
    chk("busy_in_done", busy, 1);
    if (inject) begin
      start = 1'b1;
      for (int i = 0; i < NCH; i++) shv[i] = HV'($urandom);
    end
    tick();
    start = 1'b0;
    chk("done_clear", done, 0);
    chk("busy_clear", busy, 0);
    chk("valid_idle", out_valid, 0);
    chk("done_count", n_done - d0, 1);
    if (inject) begin
      tick();
      chk("start_in_done_ignored", out_valid, 0);
      chk("done_count_after", n_done - d0, 1);
    end
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) begin
      shv[i] = '0;
      lvl[i] = '0;
    end
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ch", out_ch, 0);
    chk("rst_level", level_hv, 0);
    tick();
    nrst = 1'b0;

    // Basic and wrap: channel 0 and 9 with hand-computed vectors.
    rand_levels();
    shv[0] = 16'h0002;
    lvl[0] = 16'h0001;
    shv[9] = 16'h0001;
    lvl[9] = 16'h0040;
    run_seq(0, 1'b0);

    // Back-to-back start straight from the IDLE cycle after DONE.
    rand_levels();
    run_seq(0, 1'b0);

    rand_levels();
    run_seq(1, 1'b0);

    rand_levels();
    run_seq(0, 1'b1);

    for (int r = 0; r < 4; r++) begin
      rand_levels();
      run_seq(2, 1'b0);
    end

    // Reset in the middle of a stream.
    rand_levels();
    start = 1'b1;
    tick();
    start = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 3; t++) tick();
    chk("pre_reset_ch", out_ch, 3);
    chk("pre_reset_level", level_hv, lvl[3]);
    begin
      int d0;
      d0 = n_done;
      nrst = 1'b1;
      #1;
      chk("async_valid", out_valid, 0);
      chk("async_busy", busy, 0);
      chk("async_done", done, 0);
      chk("async_ch", out_ch, 0);
      chk("async_level", level_hv, 0);
      tick();
      tick();
      nrst = 1'b0;
      for (int t = 0; t < 3; t++) begin
        tick();
        chk("post_reset_valid", out_valid, 0);
        chk("post_reset_done", done, 0);
      end
      chk("no_done_after_abort", n_done - d0, 0);
    end
    rand_levels();
    run_seq(0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
